// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin two-client sequencer for a shared combinational ALU
// Operands are registered before reaching the ALU so client inputs never drive it directly.
module alu_arbiter #(
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [data_width-1:0] req0_a,
    input  logic [data_width-1:0] req0_b,
    input  logic [3:0]            req0_func,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [data_width-1:0] req1_a,
    input  logic [data_width-1:0] req1_b,
    input  logic [3:0]            req1_func,
    output logic [data_width-1:0] alu_a,
    output logic [data_width-1:0] alu_b,
    output logic [3:0]            alu_func,
    input  logic [data_width-1:0] alu_c,
    input  logic                  alu_ovf,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [data_width-1:0] rsp_c,
    output logic                  rsp_ovf,
    output logic [7:0]            ovf_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t                state;
    logic                  prio;
    logic                  idReg;
    logic [data_width-1:0] opA;
    logic [data_width-1:0] opB;
    logic [3:0]            opFunc;
    logic                  rspValid;
    logic                  rspId;
    logic [data_width-1:0] rspC;
    logic                  rspOvf;
    logic [7:0]            ovfCount;

    logic anyValid;
    logic grantId;
    logic canAccept;

    // A lone requester always wins; on contention the favoured client (prio) wins.
    assign anyValid  = req0_valid | req1_valid;
    assign grantId   = (req0_valid && req1_valid) ? prio : req1_valid;
    assign canAccept = reset_n && (state == IDLE) && anyValid;

    assign req0_ready = canAccept && !grantId;
    assign req1_ready = canAccept && grantId;

    assign alu_a     = opA;
    assign alu_b     = opB;
    assign alu_func  = opFunc;
    assign rsp_valid = rspValid;
    assign rsp_id    = rspId;
    assign rsp_c     = rspC;
    assign rsp_ovf   = rspOvf;
    assign ovf_count = ovfCount;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            idReg    <= 1'b0;
            opA      <= '0;
            opB      <= '0;
            opFunc   <= '0;
            rspValid <= 1'b0;
            rspId    <= 1'b0;
            rspC     <= '0;
            rspOvf   <= 1'b0;
            ovfCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyValid) begin
                        opA    <= grantId ? req1_a : req0_a;
                        opB    <= grantId ? req1_b : req0_b;
                        opFunc <= grantId ? req1_func : req0_func;
                        idReg  <= grantId;
                        prio   <= ~grantId;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rspC     <= alu_c;
                    rspOvf   <= alu_ovf;
                    rspId    <= idReg;
                    rspValid <= 1'b1;
                    if (alu_ovf && ovfCount != 8'hFF) begin
                        ovfCount <= ovfCount + 8'd1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rspValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed checks of alu_arbiter against a behavioural ALU
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_func = '0, req1_func = '0;
    logic [15:0] alu_a, alu_b, alu_c;
    logic [3:0]  alu_func;
    logic        alu_ovf;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_id;
    logic [15:0] rsp_c;
    logic        rsp_ovf;
    logic [7:0]  ovf_count;

    int nChecks = 0;
    int nPass = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: func 0 = ADD, 1 = SUB, signed overflow flag.
    always_comb begin
        alu_c   = '0;
        alu_ovf = 1'b0;
        case (alu_func)
            4'h0: begin
                alu_c   = alu_a + alu_b;
                alu_ovf = (alu_a[15] == alu_b[15]) && (alu_c[15] != alu_a[15]);
            end
            4'h1: begin
                alu_c   = alu_a - alu_b;
                alu_ovf = (alu_a[15] != alu_b[15]) && (alu_c[15] != alu_a[15]);
            end
            default: begin
                alu_c   = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    alu_arbiter #(.data_width(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_c(alu_c), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_c(rsp_c), .rsp_ovf(rsp_ovf), .ovf_count(ovf_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic doReset();
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Single request with rsp_ready held high; checks handshake and response when doCheck.
    task automatic runOp(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] f, input bit doCheck,
                         input logic [15:0] expC, input logic expOvf);
        @(negedge clk);
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_func = f;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_func = f;
        end
        #1;
        if (doCheck) begin
            check("op_ready_win", 32'(id ? req1_ready : req0_ready), 32'd1);
            check("op_ready_lose", 32'(id ? req0_ready : req1_ready), 32'd0);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (doCheck) begin
            check("op_exec_ready", 32'(req0_ready | req1_ready), 32'd0);
            check("op_exec_rspv", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        if (doCheck) begin
            check("op_rsp_valid", 32'(rsp_valid), 32'd1);
            check("op_rsp_id", 32'(rsp_id), 32'(id));
            check("op_rsp_c", 32'(rsp_c), 32'(expC));
            check("op_rsp_ovf", 32'(rsp_ovf), 32'(expOvf));
        end
        @(posedge clk);
    endtask

    initial begin
        int grants[$];
        int bothHigh;

        // Reset state
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_rsp_c", 32'(rsp_c), 32'd0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        reset_n = 1'b1;

        // Single op
        runOp(1'b0, 16'h0003, 16'h0004, 4'h0, 1'b1, 16'h0007, 1'b0);
        @(negedge clk);
        check("single_back_idle", 32'(rsp_valid), 32'd0);

        // Contention from reset
        doReset();
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_a = 16'd1;  req0_b = 16'd2;  req0_func = 4'h0; req0_valid = 1'b1;
        req1_a = 16'd10; req1_b = 16'd20; req1_func = 4'h0; req1_valid = 1'b1;
        bothHigh = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            if (req0_ready && req1_ready) bothHigh++;
            if (req0_ready || req1_ready) grants.push_back(int'(req1_ready));
            if (rsp_valid) check("ctn_rsp_c", 32'(rsp_c), rsp_id ? 32'd30 : 32'd3);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("ctn_both_ready", 32'(bothHigh), 32'd0);
        check("ctn_ngrants", 32'(grants.size()), 32'd4);
        for (int i = 0; i < grants.size() && i < 4; i++)
            check("ctn_grant_order", 32'(grants[i]), 32'(i % 2));

        // Overflow and saturation
        doReset();
        runOp(1'b1, 16'h7FFF, 16'h0001, 4'h0, 1'b1, 16'h8000, 1'b1);
        @(negedge clk);
        check("ovf_count_1", 32'(ovf_count), 32'd1);
        runOp(1'b0, 16'h8000, 16'h0001, 4'h1, 1'b1, 16'h7FFF, 1'b1);
        @(negedge clk);
        check("ovf_count_2", 32'(ovf_count), 32'd2);
        for (int i = 0; i < 253; i++)
            runOp(1'b1, 16'h7FFF, 16'h0001, 4'h0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        check("ovf_count_255", 32'(ovf_count), 32'd255);
        runOp(1'b1, 16'h7FFF, 16'h0001, 4'h0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        check("ovf_count_sat", 32'(ovf_count), 32'd255);

        // Backpressure
        @(negedge clk);
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 16'd2; req0_b = 16'd5; req0_func = 4'h0;
        @(negedge clk);
        req0_a = 16'd100; req0_b = 16'd1;
        #1;
        check("bp_exec_ready", 32'(req0_ready), 32'd0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_c", 32'(rsp_c), 32'd7);
            check("bp_rsp_id", 32'(rsp_id), 32'd0);
            check("bp_ready_held", 32'(req0_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_rspv", 32'(rsp_valid), 32'd0);
        check("bp_idle_accept", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        check("bp_new_alu_a", 32'(alu_a), 32'd100);
        @(negedge clk);
        check("bp_new_rsp_c", 32'(rsp_c), 32'd101);

        // Operand isolation
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 16'd5; req0_b = 16'd6; req0_func = 4'h0;
        @(negedge clk);
        req0_valid = 1'b0; req0_a = 16'hFFFF; req0_b = 16'hFFFF;
        #1;
        check("iso_alu_a", 32'(alu_a), 32'd5);
        check("iso_alu_b", 32'(alu_b), 32'd6);
        @(negedge clk);
        req0_a = 16'h1234;
        #1;
        check("iso_rsp_c", 32'(rsp_c), 32'd11);
        check("iso_alu_a_resp", 32'(alu_a), 32'd5);

        // Mid-op reset during EXEC
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 16'h7FFF; req1_b = 16'h0001; req1_func = 4'h0;
        @(negedge clk);
        req1_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_alu_a", 32'(alu_a), 32'd0);
        check("mid_ovf_count", 32'(ovf_count), 32'd0);
        check("mid_rsp_c", 32'(rsp_c), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_no_stale", 32'(rsp_valid), 32'd0);
        end
        check("mid_ovf_after", 32'(ovf_count), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and two-requester arbiter for the shared 16-bit combinational ALU. It accepts operation requests (A, B, FuncCode) from two clients with valid/ready handshakes and arbitrates round-robin. It drives the ALU from registered operands, captures C and OverflowFlag, and returns a tagged response. It sits between the client datapaths and the single ALU instance, so the ALU is never driven by two clients at once.

## Interface
- data_width, 16, operand/result width; must match the attached ALU
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  client 0/1 has a request
- req0_ready / req1_ready  out  1  request accepted this cycle (valid && ready at rising edge = transfer)
- req0_a, req0_b / req1_a, req1_b  in  data_width  operands
- req0_func / req1_func  in  4  ALU FuncCode
- alu_a, alu_b  out  data_width  to ALU A, B
- alu_func  out  4  to ALU FuncCode
- alu_c  in  data_width  from ALU C (combinational)
- alu_ovf  in  1  from ALU OverflowFlag
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued the response (0/1)
- rsp_c  out  data_width  result
- rsp_ovf  out  1  overflow flag for the result
- ovf_count  out  8  saturating count of completed operations with overflow

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: if any reqN_valid, a winner is chosen and its reqN_ready is driven high combinationally in the same cycle. On the clock edge, the winner's a/b/func are latched into operand registers, the winner's id goes into id_reg, and the FSM moves to EXEC. With no valid request, the FSM stays in IDLE.
- Arbitration: a 1-bit priority pointer prio names the favoured client. If only one client is valid, that client wins. If both are valid, client prio wins. After each grant, prio <= ~granted id, so the last winner becomes lowest priority. prio resets to 0.
- reqN_ready is 0 in every state other than IDLE. At most one ready is high in any cycle. Ready may depend combinationally on valid; a client must not make valid depend on ready.
- alu_a/alu_b/alu_func are driven from the operand registers only, never combinationally from client inputs. They hold their value outside EXEC.
- EXEC: alu_c and alu_ovf are sampled into result registers. If alu_ovf = 1, ovf_count increments, saturating at 255. The FSM then moves to RESP.
- RESP: rsp_valid = 1. rsp_id, rsp_c and rsp_ovf are stable until the handshake. When rsp_ready = 1 at the edge, the FSM moves to IDLE. Otherwise it stays in RESP and all outputs hold.
- Requests that arrive during EXEC or RESP wait; a client must hold valid and its data until ready.

## Timing
- Reset (reset_n low, asynchronous): state IDLE, prio 0, operand regs 0, alu_a/alu_b/alu_func 0, rsp_valid 0, rsp_id 0, rsp_c 0, rsp_ovf 0, ovf_count 0, req0_ready/req1_ready 0.
- Reset asserted mid-operation: the in-flight request is dropped with no response. After release, the FSM starts in IDLE.
- Latency: request accepted at edge E0 → EXEC during cycle E0..E1 → result captured at E1 → rsp_valid high from E1 until the rsp handshake edge.
- Minimum spacing between accepts is 3 cycles: accept, EXEC, RESP with rsp_ready held at 1, then IDLE. The next accept occurs at the edge leaving the IDLE cycle.
- Backpressure: each extra cycle with rsp_ready = 0 adds one cycle, and no new request is accepted meanwhile.
- Both clients held continuously valid: grants alternate 0,1,0,1 starting from prio.
- ovf_count at 255 with another overflow: stays 255.

## Test plan
- Single op: reset, req0 A=0x0003 B=0x0004 func=ADD, rsp_ready=1 → req0_ready high 1 cycle. rsp_valid 2 edges later with rsp_id=0, rsp_c=0x0007, rsp_ovf=0. FSM returns to IDLE.
- Contention: req0 and req1 both valid from reset with distinct ADDs → first grant to 0, second to 1, third to 0. Never both readies high in one cycle.
- Overflow: req1 A=0x7FFF B=0x0001 func=ADD → rsp_c=0x8000, rsp_ovf=1, ovf_count 0→1. Repeat 256 times → ovf_count saturates at 255.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid/rsp_c/rsp_id stable. req0_ready stays 0 despite req0_valid. Release → accept occurs after IDLE.
- Mid-op reset: pull reset_n low during EXEC (between clock edges) → all outputs are at reset values immediately. After release, no stale rsp_valid appears.
- Operand isolation: change req0_a/req0_b during EXEC/RESP → alu_a/alu_b and rsp_c unaffected.
